// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: RV32I width codes,
// FSM state encoding and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Access size in bytes; illegal codes are rejected before this matters.
  function automatic logic [2:0] size_of(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake plus the Dmem port of the load/store sequencer.
interface lsu_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [2:0]  dmem_func3;
  logic [31:0] dmem_rd;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3, dmem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           dmem_we, dmem_a, dmem_wd, dmem_func3
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3, dmem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           dmem_we, dmem_a, dmem_wd, dmem_func3
  );

endinterface

// File: rtl/lsu_extend.sv
// Combinational load-data extension by RV32I width code.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (func3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_BU:   data_o = {24'h0, data_i[7:0]};
      F3_HU:   data_o = {16'h0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: classifies one request at a time, issues it to Dmem
// as a single access or as byte accesses, and returns a registered response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter bit          SPLIT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic        we_q, we_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_illegal, req_range, req_aligned;
  logic [31:0] acc_upd, ext_in, ext_out;
  logic        last_byte;
  logic        we_cmd;

  // 33-bit end address so a wrap past 0xFFFFFFFF lands out of range
  assign req_size    = size_of(bus.req_func3);
  assign req_last    = {1'b0, bus.req_addr} + {30'b0, req_size} - 33'd1;
  assign req_illegal = (bus.req_func3 inside {3'b011, 3'b110, 3'b111}) ||
                       (bus.req_we && bus.req_func3[2]);
  assign req_range   = req_last >= 33'(MEM_BYTES);

  always_comb begin
    case (bus.req_func3[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = ~bus.req_addr[0];
      default: req_aligned = (bus.req_addr[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    acc_upd = acc_q;
    acc_upd[{idx_q, 3'b000} +: 8] = bus.dmem_rd[7:0];
  end

  assign last_byte = ({1'b0, idx_q} == (size_of(func3_q) - 3'd1));
  assign ext_in    = (state_q == ST_ACCESS) ? bus.dmem_rd : acc_upd;

  lsu_extend u_extend (
    .func3_i (func3_q),
    .data_i  (ext_in),
    .data_o  (ext_out)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    func3_d     = func3_q;
    we_d        = we_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          func3_d = bus.req_func3;
          we_d    = bus.req_we;
          idx_d   = 2'd0;
          acc_d   = 32'h0;
          if (req_illegal || req_range || (!req_aligned && !SPLIT_EN)) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_aligned) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_SPLIT;
          end
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'h0 : ext_out;
      end
      ST_SPLIT: begin
        if (!we_q) acc_d = acc_upd;
        if (last_byte) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : ext_out;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_cmd         = 1'b0;
    bus.dmem_a     = 32'h0;
    bus.dmem_wd    = 32'h0;
    bus.dmem_func3 = F3_W;
    case (state_q)
      ST_ACCESS: begin
        we_cmd         = we_q;
        bus.dmem_a     = addr_q;
        bus.dmem_wd    = wdata_q;
        bus.dmem_func3 = func3_q;
      end
      ST_SPLIT: begin
        bus.dmem_a = addr_q + {30'b0, idx_q};
        if (we_q) begin
          we_cmd         = 1'b1;
          bus.dmem_func3 = F3_B;
          bus.dmem_wd    = {24'h0, wdata_q[{idx_q, 3'b000} +: 8]};
        end else begin
          bus.dmem_func3 = F3_BU;
        end
      end
      default: ;
    endcase
  end

  // Gate with rst_n so a reset landing mid-split suppresses the pending byte write
  assign bus.dmem_we   = we_cmd & rst_n;
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      acc_q       <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    func3_q <= func3_d;
    we_q    <= we_d;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the byte-addressed data memory (Dmem).
- Accepts one load or store request at a time over a valid/ready handshake, checks func3 and address, and drives Dmem's we/a/wd/func3 port.
- Aligned accesses pass to Dmem as a single access. Misaligned halfword/word accesses are split into byte accesses.
- Returns a registered response with the final sign- or zero-extended load data, or an error flag.

Parameters:
- MEM_BYTES, 1024, Dmem size in bytes; an access whose last byte is at or beyond MEM_BYTES is an error.
- SPLIT_EN, 1, 1 = split misaligned accesses into byte accesses; 0 = misaligned access is an error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_func3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: illegal func3, range error, or misaligned with SPLIT_EN=0
- dmem_we  out  1  Dmem write enable
- dmem_a  out  32  Dmem byte address
- dmem_wd  out  32  Dmem write data
- dmem_func3  out  3  Dmem width code
- dmem_rd  in  32  Dmem combinational read data

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - dmem_we=0, dmem_a=0, dmem_wd=0, dmem_func3=3'b010.
  - Byte index and accumulator cleared.
  - Reset during SPLIT aborts the sequence; bytes already stored stay stored, and no response is issued.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready=1, dmem_we=0.
  - On req_valid, latch addr, wdata, func3 and we, then classify:
    - Illegal: func3 in {011,110,111}, or a store with func3 in {100,101}. Next state RESP with err=1.
    - Range error: addr + size - 1 >= MEM_BYTES, where size = 1, 2 or 4. Go to RESP with err=1. No Dmem write.
    - Aligned: byte access; halfword with addr[0]=0 and addr[1:0]!=11; word with addr[1:0]=00. Go to ACCESS.
    - Misaligned: SPLIT if SPLIT_EN=1, otherwise RESP with err=1.
- ACCESS (1 cycle):
  - dmem_a = latched addr, dmem_func3 = latched func3, dmem_wd = wdata, dmem_we = we.
  - For loads, capture dmem_rd into rsp_rdata at the end of the cycle.
  - Next state RESP.
- SPLIT (size cycles, index k = 0..size-1):
  - dmem_a = addr + k.
  - Store: dmem_func3 = 000, dmem_wd = {24'h0, wdata byte k}, dmem_we = 1.
  - Load: dmem_func3 = 100, dmem_we = 0, and accumulator byte k <= dmem_rd[7:0].
  - After k = size-1, apply sign/zero extension per func3 into rsp_rdata, then go to RESP.
- RESP (1 cycle): rsp_valid=1, rsp_err as classified; next state IDLE. req_ready=0.
- Latency from request accept edge to rsp_valid:
  - 2 cycles for aligned accesses.
  - size+1 cycles for split accesses.
  - 1 cycle for errors.
- dmem_we is 0 in every state except a store's ACCESS or SPLIT cycle. Loads always present we=0 to Dmem.
- rsp_rdata holds its value until the next response. For store and error responses it is driven to 0.
- Address arithmetic is 32-bit. A wrap past 0xFFFFFFFF is caught by the range check.
- Back-to-back requests: the next request is accepted in the IDLE cycle following RESP. There is no bubble beyond that cycle.

Decomposition:
- lsu_pkg holds:
  - func3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/ACCESS/SPLIT/RESP.
  - A function size_of(func3).
- Sub-module lsu_extend: combinational 32-bit extension by func3 (B/H sign extend, BU/HU zero extend, W pass-through). It is shared by the aligned and split paths.

Test Plan:
- Aligned SW 0xDEADBEEF @0x10, then LW @0x10 -> store response err=0 after 2 cycles; load rsp_rdata=0xDEADBEEF 2 cycles after accept.
- Memory 0x10..0x13 = EF BE AD DE: LB @0x12 -> 0xFFFFFFAD; LBU @0x12 -> 0x000000AD; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SPLIT_EN=1:
  - SW 0x11223344 @0x21 -> 4 byte writes at 0x21..0x24, rsp_valid 5 cycles after accept.
  - LW @0x21 -> 0x11223344.
  - LH @0x23 (bytes 0x33, 0x80 written) -> 0xFFFF8033.
- SPLIT_EN=0: LW @0x22 -> rsp_err=1 after 1 cycle, dmem_we never asserted.
- Error checks:
  - func3=011 load -> rsp_err=1.
  - SB @MEM_BYTES -> rsp_err=1, no write.
  - SW @MEM_BYTES-2 -> rsp_err=1, no write.
- rst_n=0 during the third cycle of split SW @0x31 -> no rsp_valid; bytes 0x31 and 0x32 written, 0x33 and 0x34 unchanged; req_ready=1 after reset.
